// File: rtl/jtframe_dwnld_pkg.sv
// Shared types for the ROM download packer.
// FSM states, FIFO entry layout and SDRAM lane-mask constants.
package jtframe_dwnld_pkg;

    // Byte address width carried in each FIFO entry
    localparam int DW_AW = 22;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        SDRAM_WR,
        PROM_WR
    } state_t;

    typedef struct packed {
        logic [DW_AW-1:0] addr;
        logic [7:0]       data;
    } fifo_entry_t;

    // Active-low byte-lane masks
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b11;

    function automatic logic [1:0] lane_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_fifo_sync.sv
// Generic synchronous FIFO with occupancy count and flush.
// Ports: clk, rst (async high), flush, push, pop, din, dout, full, empty, count.
module jtframe_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = count[AW];
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // A pop in the same cycle frees the slot for a push on a full FIFO.
    // A push arriving with flush becomes the first entry of the new session.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (flush | ~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= AW'(do_push);
            count  <= (AW+1)'(do_push);
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[flush ? '0 : wr_ptr] <= din;
    end

endmodule

// File: rtl/jtframe_dwnld_pack.sv
// Packs the ioctl byte download stream into SDRAM byte-lane writes,
// diverting bytes at or above PROM_START to a PROM strobe.
// In : clk_sys, RESET, downloading, ioctl_wr/addr/data, prog_ack
// Out: prog_addr/data/mask/we, prom_we/addr/data, dwnld_busy, overflow
module jtframe_dwnld_pack
    import jtframe_dwnld_pkg::*;
#(
    parameter int             AW         = DW_AW,
    parameter int             FIFO_AW    = 4,
    parameter logic [AW-1:0]  PROM_START = 22'h3F_0000,
    parameter bit             SWAB       = 1'b0
) (
    input  logic          clk_sys,
    input  logic          RESET,
    input  logic          downloading,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    output logic [AW-2:0] prog_addr,
    output logic [15:0]   prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_ack,
    output logic          prom_we,
    output logic [AW-1:0] prom_addr,
    output logic [7:0]    prom_data,
    output logic          dwnld_busy,
    output logic          overflow
);

    state_t          state;
    fifo_entry_t     din;
    fifo_entry_t     head;
    logic            dl_last;
    logic            rise;
    logic            wr_ok;
    logic            pop;
    logic            drop;
    logic            full;
    logic            empty;
    logic [FIFO_AW:0] count;

    assign din.addr = ioctl_addr;
    assign din.data = ioctl_data;

    // A new download window aborts whatever the last one left behind
    assign rise  = downloading & ~dl_last;
    assign wr_ok = ioctl_wr & downloading;
    assign pop   = (state == POP);
    assign drop  = wr_ok & full & ~pop;

    assign dwnld_busy = downloading
                      | (count != '0)
                      | (state != IDLE);

    jtframe_fifo_sync #(
        .WIDTH ($bits(fifo_entry_t)),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (RESET),
        .flush (rise),
        .push  (wr_ok),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            dl_last   <= 1'b0;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= MASK_NONE;
            prog_we   <= 1'b0;
            prom_we   <= 1'b0;
            prom_addr <= '0;
            prom_data <= '0;
            overflow  <= 1'b0;
        end else begin
            dl_last <= downloading;
            prom_we <= 1'b0;
            if (rise) begin
                state    <= IDLE;
                prog_we  <= 1'b0;
                overflow <= 1'b0;
            end else begin
                if (drop) overflow <= 1'b1;
                unique case (state)
                    IDLE: begin
                        if (!empty) state <= POP;
                    end
                    POP: begin
                        if (head.addr >= PROM_START) begin
                            prom_addr <= head.addr - PROM_START;
                            prom_data <= head.data;
                            prom_we   <= 1'b1;
                            state     <= PROM_WR;
                        end else begin
                            prog_addr <= head.addr[AW-1:1];
                            prog_data <= {2{head.data}};
                            prog_mask <= lane_mask(head.addr[0] ^ SWAB);
                            prog_we   <= 1'b1;
                            state     <= SDRAM_WR;
                        end
                    end
                    SDRAM_WR: begin
                        if (prog_ack) begin
                            prog_we <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    PROM_WR: begin
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
